// File: rtl/adc_dac_example_ctrl.sv
// Control core between the host endpoint and the FFT/IFFT cores: bin RAM and IFFT
// streamer, ADC sample FIFO feeding the FFT, FFT result FIFO for host readout, status.
module adc_dac_example_ctrl #(
    parameter int N  = 1024,
    parameter int AW = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clocks_locked,
    input  logic [31:0] wi00,
    input  logic [31:0] wi01,
    output logic [31:0] wo20,
    input  logic [31:0] trig40,
    input  logic        reg_write,
    input  logic        reg_read,
    input  logic [31:0] reg_addr,
    input  logic [31:0] reg_wdata,
    output logic [31:0] reg_rdata,
    input  logic        pi80_write,
    input  logic [31:0] pi80_data,
    input  logic        poa1_read,
    output logic [31:0] poa1_data,
    output logic [31:0] ifft_tdata,
    output logic        ifft_tvalid,
    output logic        ifft_tlast,
    input  logic        ifft_tready,
    output logic [15:0] fft_tdata,
    output logic        fft_tvalid,
    output logic        fft_tlast,
    input  logic        fft_tready,
    input  logic [31:0] fftr_tdata,
    input  logic        fftr_tvalid,
    output logic        fftr_tready,
    output logic        logic_rst,
    output logic        dac_rst
);

    localparam logic [0:0]    ST_IDLE   = 1'b0;
    localparam logic [0:0]    ST_STREAM = 1'b1;
    localparam logic [AW:0]   FRAME     = (AW+1)'(N);
    localparam logic [AW-1:0] LAST_IDX  = AW'(N-1);

    logic irst;
    assign irst = rst | wi00[1];

    logic unused_bits;
    assign unused_bits = ^{wi00[31:2], wi00[0], wi01[31:1], trig40[31:3], trig40[0],
                           reg_addr[31:AW]};

    always_ff @(posedge clk) begin
        if (rst) begin
            logic_rst <= 1'b0;
            dac_rst   <= 1'b0;
        end else begin
            logic_rst <= wi00[1];
            dac_rst   <= wi01[0];
        end
    end

    // Bin RAM; upper address bits alias onto the N bins and contents survive reset
    logic [31:0]   bin_ram [N];
    logic [AW-1:0] reg_idx;
    logic [31:0]   reg_fetch;

    assign reg_idx   = reg_addr[AW-1:0];
    assign reg_fetch = reg_write ? reg_wdata : bin_ram[reg_idx];

    always_ff @(posedge clk) begin
        if (reg_write)
            bin_ram[reg_idx] <= reg_wdata;
    end

    always_ff @(posedge clk) begin
        if (irst)
            reg_rdata <= '0;
        else if (reg_read)
            reg_rdata <= reg_fetch;
    end

    // The fetch path forwards a same-cycle register write so the streamed bin is never stale
    logic [0:0]    ifft_state;
    logic [AW-1:0] ifft_idx;
    logic [AW-1:0] ifft_next;
    logic [AW-1:0] ifft_fetch_addr;
    logic [31:0]   ifft_fetch_data;

    assign ifft_next       = ifft_idx + AW'(1);
    assign ifft_fetch_addr = (ifft_state == ST_IDLE) ? '0 : ifft_next;
    assign ifft_fetch_data = (reg_write && reg_idx == ifft_fetch_addr) ? reg_wdata
                                                                       : bin_ram[ifft_fetch_addr];

    always_ff @(posedge clk) begin
        if (irst) begin
            ifft_state  <= ST_IDLE;
            ifft_idx    <= '0;
            ifft_tdata  <= '0;
            ifft_tvalid <= 1'b0;
            ifft_tlast  <= 1'b0;
        end else begin
            case (ifft_state)
                ST_IDLE: begin
                    if (trig40[1]) begin
                        ifft_state  <= ST_STREAM;
                        ifft_idx    <= '0;
                        ifft_tdata  <= ifft_fetch_data;
                        ifft_tvalid <= 1'b1;
                        ifft_tlast  <= (LAST_IDX == '0);
                    end
                end
                default: begin
                    if (ifft_tvalid && ifft_tready) begin
                        if (ifft_idx == LAST_IDX) begin
                            ifft_state  <= ST_IDLE;
                            ifft_tvalid <= 1'b0;
                            ifft_tlast  <= 1'b0;
                        end else begin
                            ifft_idx   <= ifft_next;
                            ifft_tdata <= ifft_fetch_data;
                            ifft_tlast <= (ifft_next == LAST_IDX);
                        end
                    end
                end
            endcase
        end
    end

    // TX sample FIFO: each pipe word carries two samples, low half first
    logic [15:0]   tx_mem [N];
    logic [AW-1:0] tx_wp;
    logic [AW-1:0] tx_rp;
    logic [AW:0]   tx_count;
    logic [AW:0]   tx_space;
    logic [AW:0]   tx_inc;
    logic          tx_pop;
    logic          push_lo;
    logic          push_hi;
    logic          tx_ovf;

    assign tx_pop   = fft_tvalid && fft_tready;
    assign tx_space = FRAME - tx_count + (AW+1)'(tx_pop);
    assign push_lo  = pi80_write && (tx_space != '0);
    assign push_hi  = pi80_write && (tx_space >= (AW+1)'(2));
    assign tx_inc   = (AW+1)'(push_lo) + (AW+1)'(push_hi);

    always_ff @(posedge clk) begin
        if (push_lo)
            tx_mem[tx_wp] <= pi80_data[15:0];
        if (push_hi)
            tx_mem[tx_wp + AW'(1)] <= pi80_data[31:16];
    end

    always_ff @(posedge clk) begin
        if (irst) begin
            tx_wp    <= '0;
            tx_rp    <= '0;
            tx_count <= '0;
            tx_ovf   <= 1'b0;
        end else begin
            tx_wp    <= tx_wp + AW'(tx_inc);
            tx_rp    <= tx_rp + AW'(tx_pop);
            tx_count <= tx_count + tx_inc - (AW+1)'(tx_pop);
            if (pi80_write && !push_hi)
                tx_ovf <= 1'b1;
        end
    end

    // A frame only starts with N samples queued, so the FIFO cannot run dry mid-stream
    logic [0:0]    fft_state;
    logic [AW-1:0] fft_cnt;

    assign fft_tvalid = (fft_state == ST_STREAM);
    assign fft_tlast  = fft_tvalid && (fft_cnt == LAST_IDX);
    assign fft_tdata  = tx_mem[tx_rp];

    always_ff @(posedge clk) begin
        if (irst) begin
            fft_state <= ST_IDLE;
            fft_cnt   <= '0;
        end else begin
            case (fft_state)
                ST_IDLE: begin
                    if (trig40[2] && tx_count >= FRAME) begin
                        fft_state <= ST_STREAM;
                        fft_cnt   <= '0;
                    end
                end
                default: begin
                    if (tx_pop) begin
                        if (fft_cnt == LAST_IDX)
                            fft_state <= ST_IDLE;
                        else
                            fft_cnt <= fft_cnt + AW'(1);
                    end
                end
            endcase
        end
    end

    logic [31:0]   rx_mem [N];
    logic [AW-1:0] rx_wp;
    logic [AW-1:0] rx_rp;
    logic [AW:0]   rx_count;
    logic          rx_push;
    logic          rx_pop;
    logic          rx_empty;
    logic          rx_unf;

    assign fftr_tready = (rx_count != FRAME);
    assign rx_empty    = (rx_count == '0);
    assign rx_push     = fftr_tvalid && fftr_tready;
    assign rx_pop      = poa1_read && !rx_empty;

    always_ff @(posedge clk) begin
        if (rx_push)
            rx_mem[rx_wp] <= fftr_tdata;
    end

    always_ff @(posedge clk) begin
        if (irst) begin
            rx_wp     <= '0;
            rx_rp     <= '0;
            rx_count  <= '0;
            rx_unf    <= 1'b0;
            poa1_data <= '0;
        end else begin
            rx_wp    <= rx_wp + AW'(rx_push);
            rx_rp    <= rx_rp + AW'(rx_pop);
            rx_count <= rx_count + (AW+1)'(rx_push) - (AW+1)'(rx_pop);
            if (poa1_read) begin
                poa1_data <= rx_empty ? 32'd0 : rx_mem[rx_rp];
                if (rx_empty)
                    rx_unf <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (irst)
            wo20 <= {25'd0, 3'b000, 1'b1, 2'b00, clocks_locked};
        else
            wo20 <= {25'd0, rx_unf, tx_ovf, (tx_count >= FRAME), (rx_count < FRAME),
                     (fft_state == ST_STREAM), (ifft_state == ST_STREAM), clocks_locked};
    end

endmodule

// File: tb/tb_adc_dac_example_ctrl.sv
// Scoreboard bench for adc_dac_example_ctrl: bin streaming, TX/FFT path,
// RX readout, sticky status bits and mid-stream logic reset.
module tb_adc_dac_example_ctrl;

    localparam int N = 1024;

    logic        clk;
    logic        rst;
    logic        clocks_locked;
    logic [31:0] wi00, wi01, wo20, trig40;
    logic        reg_write, reg_read;
    logic [31:0] reg_addr, reg_wdata, reg_rdata;
    logic        pi80_write;
    logic [31:0] pi80_data;
    logic        poa1_read;
    logic [31:0] poa1_data;
    logic [31:0] ifft_tdata;
    logic        ifft_tvalid, ifft_tlast, ifft_tready;
    logic [15:0] fft_tdata;
    logic        fft_tvalid, fft_tlast, fft_tready;
    logic [31:0] fftr_tdata;
    logic        fftr_tvalid, fftr_tready;
    logic        logic_rst, dac_rst;

    adc_dac_example_ctrl #(.N(N), .AW(10)) dut (
        .clk(clk), .rst(rst), .clocks_locked(clocks_locked),
        .wi00(wi00), .wi01(wi01), .wo20(wo20), .trig40(trig40),
        .reg_write(reg_write), .reg_read(reg_read), .reg_addr(reg_addr),
        .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
        .pi80_write(pi80_write), .pi80_data(pi80_data),
        .poa1_read(poa1_read), .poa1_data(poa1_data),
        .ifft_tdata(ifft_tdata), .ifft_tvalid(ifft_tvalid), .ifft_tlast(ifft_tlast),
        .ifft_tready(ifft_tready),
        .fft_tdata(fft_tdata), .fft_tvalid(fft_tvalid), .fft_tlast(fft_tlast),
        .fft_tready(fft_tready),
        .fftr_tdata(fftr_tdata), .fftr_tvalid(fftr_tvalid), .fftr_tready(fftr_tready),
        .logic_rst(logic_rst), .dac_rst(dac_rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;
    int fft_pos = 0;

    logic [31:0] bin_model [N];
    logic [31:0] ifft_q [$];
    logic [15:0] fft_q [$];
    logic [31:0] rx_q [$];

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus();
        rst = 1'b0; clocks_locked = 1'b1; wi00 = '0; wi01 = '0; trig40 = '0;
        reg_write = 1'b0; reg_read = 1'b0; reg_addr = '0; reg_wdata = '0;
        pi80_write = 1'b0; pi80_data = '0; poa1_read = 1'b0;
        ifft_tready = 1'b0; fft_tready = 1'b0; fftr_tdata = '0; fftr_tvalid = 1'b0;
    endtask

    task automatic regWrite(input int addr, input logic [31:0] data);
        reg_write = 1'b1; reg_addr = addr; reg_wdata = data;
        bin_model[addr % N] = data;
        @(negedge clk);
        reg_write = 1'b0;
    endtask

    // Model accepts samples only while fewer than N are queued; callers never pop at the same time
    task automatic pushWord(input logic [31:0] w);
        pi80_write = 1'b1; pi80_data = w;
        if (fft_q.size() < N) fft_q.push_back(w[15:0]);
        if (fft_q.size() < N) fft_q.push_back(w[31:16]);
        @(negedge clk);
        pi80_write = 1'b0;
    endtask

    task automatic pulseTrig(input logic [31:0] bits);
        trig40 = bits;
        @(negedge clk);
        trig40 = '0;
    endtask

    task automatic drainFft(input int beats);
        int got = 0;
        for (int cyc = 0; cyc < beats * 8 + 50; cyc++) begin
            if (got == beats) break;
            fft_tready = ($urandom_range(0, 3) != 0);
            if (fft_tvalid && fft_tready) begin
                checkOutput("fft_data", {16'd0, fft_tdata}, {16'd0, fft_q.pop_front()});
                checkOutput("fft_last", {31'd0, fft_tlast}, {31'd0, fft_pos == N - 1});
                fft_pos = (fft_pos + 1) % N;
                got++;
            end
            @(negedge clk);
        end
        fft_tready = 1'b0;
        checkOutput("fft_beats", got, beats);
    endtask

    initial begin
        int beats;
        int fed;
        logic saw_valid;

        applyStimulus();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_wo20", wo20, 32'h9);
        checkOutput("rst_ifft_valid", {31'd0, ifft_tvalid}, 0);
        checkOutput("rst_fft_valid", {31'd0, fft_tvalid}, 0);
        checkOutput("rst_fftr_ready", {31'd0, fftr_tready}, 1);
        checkOutput("rst_poa1", poa1_data, 0);
        checkOutput("rst_rdata", reg_rdata, 0);
        checkOutput("rst_outs", {30'd0, logic_rst, dac_rst}, 0);

        for (int a = 0; a < 2 * N; a++) regWrite(a, 32'd0);
        regWrite(4, 32'h0001FFFF);
        regWrite(488, 32'h0001FFFF);
        regWrite(2047, 32'hABCD0001);

        reg_read = 1'b1; reg_addr = 32'd1028;
        @(negedge clk);
        reg_read = 1'b0; reg_addr = 32'd0;
        checkOutput("reg_read_alias", reg_rdata, 32'h0001FFFF);
        @(negedge clk);
        checkOutput("reg_read_hold", reg_rdata, 32'h0001FFFF);

        for (int i = 0; i < N; i++) ifft_q.push_back(bin_model[i]);
        pulseTrig(32'h2);
        beats = 0;
        for (int cyc = 0; cyc < 8000 && beats < N; cyc++) begin
            ifft_tready = ($urandom_range(0, 3) != 0);
            if (ifft_tvalid && ifft_tready) begin
                checkOutput("ifft_data", ifft_tdata, ifft_q.pop_front());
                checkOutput("ifft_last", {31'd0, ifft_tlast}, {31'd0, beats == N - 1});
                beats++;
            end
            @(negedge clk);
        end
        ifft_tready = 1'b0;
        checkOutput("ifft_beats", beats, N);
        checkOutput("ifft_idle_valid", {31'd0, ifft_tvalid}, 0);
        @(negedge clk);
        checkOutput("ifft_busy_clear", {31'd0, wo20[1]}, 0);

        for (int i = 0; i < N / 2; i++) pushWord($urandom);
        @(negedge clk);
        checkOutput("tx_full_flag", {30'd0, wo20[5:4]}, 32'h1);
        pushWord($urandom);
        @(negedge clk);
        checkOutput("tx_ovf_flag", {30'd0, wo20[5:4]}, 32'h3);

        // One sample out, then a word into the single free slot: high half must be dropped
        pulseTrig(32'h4);
        drainFft(1);
        pushWord($urandom);
        drainFft(N - 1);
        @(negedge clk);
        checkOutput("fft_done_valid", {31'd0, fft_tvalid}, 0);
        checkOutput("fft_done_status", {29'd0, wo20[4], wo20[2], 1'b0}, 0);

        for (int i = 0; i < N / 2 - 1; i++) pushWord($urandom);
        @(negedge clk);
        pulseTrig(32'h4);
        saw_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            saw_valid |= fft_tvalid;
            @(negedge clk);
        end
        checkOutput("fft_short_trig", {31'd0, saw_valid}, 0);
        pushWord($urandom);
        @(negedge clk);
        checkOutput("tx_refill_flag", {31'd0, wo20[4]}, 1);
        pulseTrig(32'h4);
        drainFft(N);
        @(negedge clk);
        checkOutput("tx_drain_flag", {31'd0, wo20[4]}, 0);

        fed = 0;
        for (int cyc = 0; cyc < 6000 && fed < N; cyc++) begin
            fftr_tvalid = $urandom_range(0, 1);
            fftr_tdata  = $urandom;
            if (fftr_tvalid && fftr_tready) begin
                rx_q.push_back(fftr_tdata);
                fed++;
            end
            @(negedge clk);
        end
        checkOutput("rx_fed", fed, N);
        fftr_tvalid = 1'b1; fftr_tdata = 32'hDEADBEEF;
        @(negedge clk);
        fftr_tvalid = 1'b0;
        checkOutput("rx_full_ready", {31'd0, fftr_tready}, 0);
        checkOutput("rx_full_flag", {31'd0, wo20[3]}, 0);

        for (int i = 0; i < N; i++) begin
            poa1_read = 1'b1;
            @(negedge clk);
            poa1_read = 1'b0;
            checkOutput("rx_data", poa1_data, rx_q.pop_front());
        end
        poa1_read = 1'b1;
        @(negedge clk);
        poa1_read = 1'b0;
        checkOutput("rx_underflow_data", poa1_data, 0);
        @(negedge clk);
        checkOutput("rx_unf_flag", {29'd0, wo20[6], wo20[3], fftr_tready}, 32'h7);

        ifft_tready = 1'b1;
        pulseTrig(32'h2);
        repeat (5) @(negedge clk);
        checkOutput("mid_ifft_busy", {31'd0, wo20[1]}, 1);
        wi00 = 32'h2;
        @(negedge clk);
        checkOutput("mid_rst_valid", {31'd0, ifft_tvalid}, 0);
        checkOutput("mid_rst_logic_rst", {31'd0, logic_rst}, 1);
        checkOutput("mid_rst_wo20", wo20, 32'h9);
        wi00 = 32'h0; ifft_tready = 1'b0;
        @(negedge clk);
        checkOutput("logic_rst_release", {31'd0, logic_rst}, 0);
        checkOutput("mid_rst_idle", {31'd0, ifft_tvalid}, 0);

        reg_read = 1'b1; reg_addr = 32'd488;
        @(negedge clk);
        reg_read = 1'b0;
        checkOutput("ram_survives_rst", reg_rdata, 32'h0001FFFF);

        wi01 = 32'h1;
        @(negedge clk);
        checkOutput("dac_rst_set", {31'd0, dac_rst}, 1);
        wi01 = 32'h0;
        @(negedge clk);
        checkOutput("dac_rst_clear", {31'd0, dac_rst}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
